// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: NCH independent monostable pulse channels with
// runtime length, retrigger, holdoff, abort, done and missed strobes.
module pulse_gen_multi #(
  parameter int NCH     = 4,
  parameter int CW      = 8,
  parameter int HOLDOFF = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en_i,
  input  logic [NCH-1:0]    retrig_i,
  input  logic [NCH*CW-1:0] len_i,
  input  logic [NCH-1:0]    trig_i,
  output logic [NCH-1:0]    y_o,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH-1:0]    done_o,
  output logic [NCH-1:0]    missed_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_HOLD
  } state_e;

  localparam logic [CW-1:0] HO  = CW'(HOLDOFF);
  localparam logic [CW-1:0] ONE = CW'(1);

  if (NCH < 1) begin : g_bad_nch
    $error("pulse_gen_multi: NCH must be >= 1");
  end
  if (CW < 2) begin : g_bad_cw
    $error("pulse_gen_multi: CW must be >= 2");
  end
  if (HOLDOFF < 0 || HOLDOFF > (2**CW) - 1) begin : g_bad_ho
    $error("pulse_gen_multi: HOLDOFF out of range");
  end

  // Low for the first edge after reset, so a trigger already high
  // when reset releases is seen as a level, not as an edge.
  logic arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arm_q <= 1'b0;
    else        arm_q <= 1'b1;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d, len;
    logic          trig_q, rise, done_d, missed_d;
    logic          y_q, busy_q, done_q, missed_q;

    assign len  = len_i[k*CW +: CW];
    assign rise = trig_i[k] & ~trig_q & arm_q;

    always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      missed_d = 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (rise && en_i[k] && len != '0) begin
            st_d  = S_PULSE;
            cnt_d = len;
          end else begin
            missed_d = rise;
          end
        end
        S_PULSE: begin
          missed_d = rise;
          if (!en_i[k]) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end else if (rise && retrig_i[k] && len != '0) begin
            cnt_d    = len;
            missed_d = 1'b0;
          end else if (cnt_q <= ONE) begin
            done_d = 1'b1;
            st_d   = (HO == '0) ? S_IDLE : S_HOLD;
            cnt_d  = HO;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_HOLD: begin
          missed_d = rise;
          if (!en_i[k] || cnt_q <= ONE) begin
            st_d  = S_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          st_d  = S_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q     <= S_IDLE;
        cnt_q    <= '0;
        trig_q   <= 1'b0;
        y_q      <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        missed_q <= 1'b0;
      end else begin
        st_q     <= st_d;
        cnt_q    <= cnt_d;
        trig_q   <= trig_i[k];
        y_q      <= (st_d == S_PULSE);
        busy_q   <= (st_d != S_IDLE);
        done_q   <= done_d;
        missed_q <= missed_d;
      end
    end

    assign y_o[k]      = y_q;
    assign busy_o[k]   = busy_q;
    assign done_o[k]   = done_q;
    assign missed_o[k] = missed_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb_pulse_gen_multi: scenario bench for pulse_gen_multi, with a
// HOLDOFF=0 and a HOLDOFF=3 instance fed from the same inputs.
module tb_pulse_gen_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en_i;
  logic [3:0]  retrig_i;
  logic [31:0] len_i;
  logic [3:0]  trig_i;

  logic [3:0] y0, b0, d0, m0;
  logic [3:0] y3, b3, d3, m3;
  logic [15:0] obs0, obs3;

  logic [15:0] sb_q [$];
  int checks   = 0;
  int failures = 0;

  assign obs0 = {y0, b0, d0, m0};
  assign obs3 = {y3, b3, d3, m3};

  always #5 clk = ~clk;

  pulse_gen_multi #(.NCH(4), .CW(8), .HOLDOFF(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .retrig_i (retrig_i),
    .len_i    (len_i),
    .trig_i   (trig_i),
    .y_o      (y0),
    .busy_o   (b0),
    .done_o   (d0),
    .missed_o (m0)
  );

  pulse_gen_multi #(.NCH(4), .CW(8), .HOLDOFF(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .retrig_i (retrig_i),
    .len_i    (len_i),
    .trig_i   (trig_i),
    .y_o      (y3),
    .busy_o   (b3),
    .done_o   (d3),
    .missed_o (m3)
  );

  task automatic idle(input int n);
    trig_i = 4'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst_n    = 1'b0;
    en_i     = 4'hF;
    retrig_i = 4'h0;
    len_i    = 32'h05050505;
    trig_i   = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    e = sb_q.pop_front();
    checks++;
    if (obs0 !== e) begin
      failures++;
      $display("FAIL reset_h0 got=%h exp=%h", obs0, e);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs3 !== e) begin
      failures++;
      $display("FAIL reset_h3 got=%h exp=%h", obs3, e);
    end
    #3 rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_single();
    logic [3:0]  tt [7] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [15:0] et [7] = '{16'h1100, 16'h1100, 16'h1100, 16'h1100,
                            16'h1100, 16'h0010, 16'h0000};
    logic [15:0] e;
    retrig_i = 4'h0;
    len_i    = 32'h07070705;
    for (int i = 0; i < 7; i++) begin
      trig_i = tt[i];
      sb_q.push_back(et[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        failures++;
        $display("FAIL single cyc%0d got=%h exp=%h", i, obs0, e);
      end
    end
    idle(3);
  endtask

  task automatic test_retrig();
    logic [3:0]  tt [8] = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [15:0] et [8] = '{16'h2200, 16'h2200, 16'h2200, 16'h2200,
                            16'h2200, 16'h2200, 16'h0020, 16'h0000};
    logic [15:0] e;
    retrig_i = 4'h2;
    len_i    = 32'h07070407;
    for (int i = 0; i < 8; i++) begin
      trig_i = tt[i];
      sb_q.push_back(et[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        failures++;
        $display("FAIL retrig cyc%0d got=%h exp=%h", i, obs0, e);
      end
    end
    idle(3);
  endtask

  task automatic test_no_retrig();
    logic [3:0]  tt [6] = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
    logic [15:0] et [6] = '{16'h4400, 16'h4400, 16'h4404,
                            16'h4400, 16'h0040, 16'h0000};
    logic [15:0] e;
    retrig_i = 4'h0;
    len_i    = 32'h07040707;
    for (int i = 0; i < 6; i++) begin
      trig_i = tt[i];
      sb_q.push_back(et[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        failures++;
        $display("FAIL no_retrig cyc%0d got=%h exp=%h", i, obs0, e);
      end
    end
    idle(6);
  endtask

  task automatic test_holdoff();
    logic [3:0]  tt [12] = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0,
                             4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [15:0] et [12] = '{16'h1100, 16'h1100, 16'h0110, 16'h0101,
                             16'h0100, 16'h0000, 16'h1100, 16'h1100,
                             16'h0110, 16'h0100, 16'h0100, 16'h0000};
    logic [15:0] e;
    retrig_i = 4'h0;
    len_i    = 32'h07070702;
    for (int i = 0; i < 12; i++) begin
      trig_i = tt[i];
      sb_q.push_back(et[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs3 !== e) begin
        failures++;
        $display("FAIL holdoff cyc%0d got=%h exp=%h", i, obs3, e);
      end
    end
    idle(4);
  endtask

  task automatic test_len0_abort();
    logic [3:0]  tt [8] = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};
    logic [3:0]  ee [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF};
    logic [15:0] et [8] = '{16'h0008, 16'h0000, 16'h8800, 16'h8800,
                            16'h8800, 16'h0008, 16'h0000, 16'h0000};
    logic [15:0] e;
    retrig_i = 4'h0;
    len_i    = 32'h00070707;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) len_i[31:24] = 8'd10;
      trig_i = tt[i];
      en_i   = ee[i];
      sb_q.push_back(et[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        failures++;
        $display("FAIL len0_abort cyc%0d got=%h exp=%h", i, obs0, e);
      end
    end
    en_i = 4'hF;
    idle(4);
  endtask

  task automatic test_reset_mid_pulse();
    logic [15:0] e;
    retrig_i = 4'h0;
    len_i    = 32'h0707070A;
    trig_i   = 4'h1;
    sb_q.push_back(16'h1100);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (obs0 !== e) begin
      failures++;
      $display("FAIL mid_pre got=%h exp=%h", obs0, e);
    end
    #3 rst_n = 1'b0;
    #1;
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    e = sb_q.pop_front();
    checks++;
    if (obs0 !== e) begin
      failures++;
      $display("FAIL mid_async_h0 got=%h exp=%h", obs0, e);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs3 !== e) begin
      failures++;
      $display("FAIL mid_async_h3 got=%h exp=%h", obs3, e);
    end
    @(posedge clk);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      trig_i = (i == 3) ? 4'h0 : 4'h1;
      sb_q.push_back((i == 4) ? 16'h1100 : 16'h0000);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        failures++;
        $display("FAIL mid_post cyc%0d got=%h exp=%h", i, obs0, e);
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrig();
    test_no_retrig();
    test_holdoff();
    test_len0_abort();
    test_reset_mid_pulse();
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
